// File: rtl/wb_shared_bus.sv
// Wishbone classic shared-bus interconnect: round-robin arbitration held for the
// whole CYC, slave decode from high address bits, unmapped and timeout bus errors.
module wb_shared_bus #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int DEC_MSB     = 31,
  parameter int DEC_LSB     = 28,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [4*NUM_MASTERS-1:0]    m_sel_i,
  input  logic [32*NUM_MASTERS-1:0]   m_adr_i,
  input  logic [32*NUM_MASTERS-1:0]   m_dat_i,
  output logic [32*NUM_MASTERS-1:0]   m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_sel_o,
  output logic [31:0]                 s_adr_o,
  output logic [31:0]                 s_dat_o,
  input  logic [32*NUM_SLAVES-1:0]    s_dat_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        busy_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int DW = DEC_MSB - DEC_LSB + 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                 state_r, state_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_s;
  logic [PW-1:0]          ptr_r, ptr_s;
  logic [CW-1:0]          tcnt_r, tcnt_s;
  logic                   uflag_r, uflag_s;
  logic                   uerr_r, uerr_s;
  logic [31:0]            uadr_r, uadr_s;

  logic                   busy_s;
  logic                   g_cyc_s, g_stb_s, g_we_s;
  logic [3:0]             g_sel_s;
  logic [31:0]            g_adr_s, g_dat_s;
  logic [DW-1:0]          dec_idx_s;
  logic                   mapped_s;
  logic [NUM_SLAVES-1:0]  hit_s;
  logic                   sel_ack_s, sel_err_s;
  logic [31:0]            sel_dat_s;
  logic                   tmo_hit_s, tmo_err_s, uerr_out_s, err_s;
  logic                   win_found_s;
  logic [NUM_MASTERS-1:0] win_oh_s;
  logic [PW-1:0]          win_nxt_s;
  logic                   req_s;

  assign busy_s = (state_r == ST_BUSY);

  // Forward the granted master's request; grant_r is one-hot or zero.
  always_comb begin
    g_cyc_s = 1'b0;
    g_stb_s = 1'b0;
    g_we_s  = 1'b0;
    g_sel_s = 4'h0;
    g_adr_s = 32'h0;
    g_dat_s = 32'h0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      g_cyc_s = g_cyc_s | (grant_r[k] & m_cyc_i[k]);
      g_stb_s = g_stb_s | (grant_r[k] & m_stb_i[k]);
      g_we_s  = g_we_s  | (grant_r[k] & m_we_i[k]);
      g_sel_s = g_sel_s | ({4{grant_r[k]}} & m_sel_i[4*k +: 4]);
      g_adr_s = g_adr_s | ({32{grant_r[k]}} & m_adr_i[32*k +: 32]);
      g_dat_s = g_dat_s | ({32{grant_r[k]}} & m_dat_i[32*k +: 32]);
    end
  end

  assign dec_idx_s = g_adr_s[DEC_MSB:DEC_LSB];
  assign mapped_s  = (32'(dec_idx_s) < 32'(NUM_SLAVES));

  // Slave select and response mux.
  always_comb begin
    hit_s     = '0;
    sel_ack_s = 1'b0;
    sel_err_s = 1'b0;
    sel_dat_s = 32'h0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      hit_s[j]  = busy_s & mapped_s & (32'(dec_idx_s) == 32'(j));
      sel_ack_s = sel_ack_s | (hit_s[j] & s_ack_i[j]);
      sel_err_s = sel_err_s | (hit_s[j] & s_err_i[j]);
      sel_dat_s = sel_dat_s | ({32{hit_s[j]}} & s_dat_i[32*j +: 32]);
    end
  end

  // Stall timeout: stb is pulled from the slave in the expiry cycle, but a
  // coincident slave ACK still completes the beat and suppresses the error.
  assign tmo_hit_s  = TMO_EN && busy_s && (tcnt_r == TMO_MAX);
  assign tmo_err_s  = tmo_hit_s & g_stb_s & ~sel_ack_s & ~sel_err_s;
  assign uerr_out_s = uerr_r & busy_s;
  assign err_s      = ~sel_ack_s & (sel_err_s | uerr_out_s | tmo_err_s);

  assign s_cyc_o = hit_s & {NUM_SLAVES{g_cyc_s}};
  assign s_stb_o = hit_s & {NUM_SLAVES{g_stb_s & ~tmo_hit_s}};
  assign s_we_o  = g_we_s;
  assign s_sel_o = g_sel_s;
  assign s_adr_o = g_adr_s;
  assign s_dat_o = g_dat_s;
  assign m_dat_o = {NUM_MASTERS{sel_dat_s}};
  assign m_ack_o = grant_r & {NUM_MASTERS{busy_s & sel_ack_s}};
  assign m_err_o = grant_r & {NUM_MASTERS{busy_s & err_s}};
  assign grant_o = grant_r;
  assign busy_o  = busy_s;

  // Round-robin search starting at ptr_r, wrapping modulo NUM_MASTERS.
  always_comb begin
    win_found_s = 1'b0;
    win_oh_s    = '0;
    win_nxt_s   = '0;
    req_s       = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        req_s = m_cyc_i[k] && ((int'(ptr_r) + i == k) || (int'(ptr_r) + i == k + NUM_MASTERS));
        if (req_s && !win_found_s) begin
          win_found_s = 1'b1;
          win_oh_s    = '0;
          win_oh_s[k] = 1'b1;
          win_nxt_s   = (k == NUM_MASTERS - 1) ? '0 : PW'(k + 1);
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
  end

  // Bus ownership next state.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_s = ST_BUSY;
          grant_s = win_oh_s;
          ptr_s   = win_nxt_s;
        end else begin
          state_s = ST_IDLE;
          grant_s = '0;
        end
      end
      ST_BUSY: begin
        if (!g_cyc_s) begin
          state_s = ST_IDLE;
          grant_s = '0;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // Stall counter next value; saturates rather than wrapping.
  always_comb begin
    tcnt_s = tcnt_r;
    if (!TMO_EN || !busy_s || !g_stb_s || sel_ack_s || sel_err_s || uerr_out_s || tmo_hit_s) begin
      tcnt_s = '0;
    end else if (tcnt_r != TMO_MAX) begin
      tcnt_s = tcnt_r + CW'(1);
    end else begin
      tcnt_s = tcnt_r;
    end
  end

  // Unmapped access: one error pulse per beat, a beat being a new stb or address.
  always_comb begin
    uflag_s = uflag_r;
    uerr_s  = 1'b0;
    uadr_s  = uadr_r;
    if (!busy_s || !g_stb_s || mapped_s) begin
      uflag_s = 1'b0;
    end else if (!uflag_r || (g_adr_s != uadr_r)) begin
      uflag_s = 1'b1;
      uerr_s  = 1'b1;
      uadr_s  = g_adr_s;
    end else begin
      uflag_s = uflag_r;
    end
  end

  // State, grant and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      ptr_r   <= ptr_s;
    end
  end

  // Error bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r  <= '0;
      uflag_r <= 1'b0;
      uerr_r  <= 1'b0;
      uadr_r  <= 32'h0;
    end else begin
      tcnt_r  <= tcnt_s;
      uflag_r <= uflag_s;
      uerr_r  <= uerr_s;
      uadr_r  <= uadr_s;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: 2 masters, 4 slaves, TIMEOUT=8.
module tb_wb_shared_bus;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   m_cyc, m_stb, m_we;
  logic [7:0]   m_sel;
  logic [63:0]  m_adr, m_wdat;
  logic [63:0]  m_rdat;
  logic [1:0]   m_ack, m_err;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr, s_wdat;
  logic [127:0] s_rdat;
  logic [3:0]   s_ack, s_err;
  logic [1:0]   grant;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int left0, left1;
  logic [1:0]  exp_g;
  logic [31:0] badr [3] = '{32'h0000_0000, 32'h3000_0000, 32'h0000_0100};
  logic [3:0]  bhit [3] = '{4'b0001, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  wb_shared_bus #(
    .NUM_MASTERS(2), .NUM_SLAVES(4), .DEC_MSB(31), .DEC_LSB(28), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_dat_o(m_rdat),
    .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat),
    .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    s_ack = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    m_cyc  = 2'b00; m_stb = 2'b00; m_we = 2'b00; m_sel = 8'h00;
    m_adr  = 64'h0; m_wdat = 64'h0;
    s_ack  = 4'h0;  s_err = 4'h0;
    s_rdat = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_s_cyc", s_cyc, 4'h0);
    check_val("rst_s_stb", s_stb, 4'h0);
    check_val("rst_m_ack", m_ack, 2'b00);
    check_val("rst_m_err", m_err, 2'b00);
    rst_n = 1'b1;

    // single master write to slave 2, zero-wait ack
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[3:0] = 4'hF;
    m_adr[31:0] = 32'h2000_0004; m_wdat[31:0] = 32'hA5A5_0001;
    #1 check_val("t1_arb_latency", grant, 2'b00);
    clk_step();
    s_ack[2] = 1'b1;
    #1;
    check_val("t1_grant", grant, 2'b01);
    check_val("t1_busy", busy, 1'b1);
    check_val("t1_s_stb", s_stb, 4'b0100);
    check_val("t1_s_cyc", s_cyc, 4'b0100);
    check_val("t1_s_adr", s_adr, 32'h2000_0004);
    check_val("t1_s_dat", s_wdat, 32'hA5A5_0001);
    check_val("t1_s_we", s_we, 1'b1);
    check_val("t1_s_sel", s_sel, 4'hF);
    check_val("t1_m_ack", m_ack, 2'b01);
    check_val("t1_m_err", m_err, 2'b00);
    check_val("t1_m_dat", m_rdat, {32'hD000_0002, 32'hD000_0002});
    clk_step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack[2] = 1'b0;
    #1;
    check_val("t1_release_busy", busy, 1'b1);
    check_val("t1_release_s_cyc", s_cyc, 4'h0);
    clk_step();
    #1;
    check_val("t1_idle_grant", grant, 2'b00);
    check_val("t1_idle_busy", busy, 1'b0);

    // round-robin between two always-requesting masters
    do_reset();
    left0 = 4; left1 = 4;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00; m_sel = 8'hFF;
    m_adr = {32'h1000_0000, 32'h1000_0000};
    for (int t = 0; t < 8; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      clk_step();
      s_ack[1] = 1'b1;
      #1;
      check_val("rr_grant", grant, exp_g);
      check_val("rr_ack", m_ack, exp_g);
      clk_step();
      s_ack[1] = 1'b0;
      m_cyc = m_cyc & ~exp_g;
      m_stb = m_stb & ~exp_g;
      if (exp_g == 2'b01) left0--; else left1--;
      clk_step();
      #1 check_val("rr_gap", grant, 2'b00);
      if (exp_g == 2'b01 && left0 > 0) begin
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      end else if (exp_g == 2'b10 && left1 > 0) begin
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      end
    end

    // unmapped read by master 1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[63:32] = 32'h5000_0000;
    clk_step();
    #1;
    check_val("unm_grant", grant, 2'b10);
    check_val("unm_s_stb", s_stb, 4'h0);
    check_val("unm_s_cyc", s_cyc, 4'h0);
    check_val("unm_err_first", m_err, 2'b00);
    clk_step();
    #1;
    check_val("unm_err_pulse", m_err, 2'b10);
    check_val("unm_no_ack", m_ack, 2'b00);
    clk_step();
    #1 check_val("unm_err_once", m_err, 2'b00);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    clk_step();
    #1 check_val("unm_idle", busy, 1'b0);

    // timeout on slave 0 that never acks
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[31:0] = 32'h0000_0010;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check_val("tmo_stall_stb", s_stb, 4'b0001);
      check_val("tmo_stall_err", m_err, 2'b00);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    check_val("tmo_stb_low", s_stb, 4'b0000);
    check_val("tmo_err", m_err, 2'b01);
    check_val("tmo_no_ack", m_ack, 2'b00);
    clk_step();
    #1;
    check_val("tmo_err_once", m_err, 2'b00);
    check_val("tmo_restart_stb", s_stb, 4'b0001);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    clk_step();

    // ack arriving exactly at expiry wins over the timeout
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk);
    repeat (8) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    s_ack[0] = 1'b1;
    #1;
    check_val("tmo_ack_wins_ack", m_ack, 2'b01);
    check_val("tmo_ack_wins_err", m_err, 2'b00);
    clk_step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack[0] = 1'b0;
    #1 check_val("tmo_ack_after_err", m_err, 2'b00);
    clk_step();

    // burst by master 0 across slaves while master 1 waits
    m_cyc[0] = 1'b1; m_stb[0] = 1'b0;
    clk_step();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[63:32] = 32'h2000_0000;
    for (int b = 0; b < 3; b++) begin
      m_stb[0] = 1'b1; m_adr[31:0] = badr[b]; s_ack = bhit[b];
      #1;
      check_val("burst_grant", grant, 2'b01);
      check_val("burst_s_stb", s_stb, bhit[b]);
      check_val("burst_s_cyc", s_cyc, bhit[b]);
      check_val("burst_ack", m_ack, 2'b01);
      clk_step();
    end
    s_ack = 4'h0; m_stb[0] = 1'b0;
    #1;
    check_val("burst_hold", grant, 2'b01);
    check_val("burst_hold_cyc", s_cyc, 4'b0001);
    m_cyc[0] = 1'b0;
    clk_step();
    #1 check_val("burst_gap", grant, 2'b00);
    clk_step();
    #1;
    check_val("m1_grant", grant, 2'b10);
    check_val("m1_s_stb", s_stb, 4'b0100);
    s_ack[2] = 1'b1;
    #1 check_val("m1_ack", m_ack, 2'b10);

    // asynchronous reset in the middle of the beat
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_grant", grant, 2'b00);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_s_stb", s_stb, 4'h0);
    check_val("arst_s_cyc", s_cyc, 4'h0);
    check_val("arst_m_ack", m_ack, 2'b00);
    check_val("arst_m_err", m_err, 2'b00);
    @(negedge clk);
    rst_n = 1'b1; s_ack = 4'h0;
    m_cyc = 2'b11; m_stb = 2'b11; m_adr[31:0] = 32'h0000_0000;
    clk_step();
    #1 check_val("arst_first_winner", grant, 2'b01);
    m_cyc = 2'b00; m_stb = 2'b00;
    clk_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
